alu_muldiv_seq: RTL and testbench

Multi-cycle sequencer that runs 32-bit unsigned multiply (low word) and unsigned divide on the shared single-cycle ALU. It performs no add, subtract or compare arithmetic itself. It drives the ALU's opcode and operand inputs, captures its result and zero flag each cycle, and steps an internal state machine. It sits beside the datapath ALU and serves MULU/DIVU requests from the control unit through a start/busy/done handshake.

---
 rtl/alu_muldiv_seq.sv | 189 ++++++++++++++++++
 tb/tb_alu_muldiv_seq.sv | 175 +++++++++++++++++
 2 files changed

// File: rtl/alu_muldiv_seq.sv
// ============================================================================
// Module   : alu_muldiv_seq
// Purpose  : 32-bit unsigned multiply (low word) / divide sequencer that runs
//            its arithmetic on the shared single-cycle datapath ALU.
// Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module alu_muldiv_seq (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic        op,
  input  logic [31:0] a_in,
  input  logic [31:0] b_in,
  output logic        busy,
  output logic        done,
  output logic [31:0] result_lo,
  output logic [31:0] result_hi,
  output logic        div_by_zero,
  output logic [3:0]  alu_op,
  output logic [31:0] alu_a,
  output logic [31:0] alu_b,
  input  logic [31:0] alu_result,
  input  logic        alu_zero
);

  localparam logic [3:0] C_ALU_ADD  = 4'b0000;
  localparam logic [3:0] C_ALU_SUB  = 4'b0001;
  localparam logic [3:0] C_ALU_SLTU = 4'b0101;

  typedef enum logic [2:0] {
    S_IDLE     = 3'd0,
    S_MUL_STEP = 3'd1,
    S_DIV_CMP  = 3'd2,
    S_DIV_SUB  = 3'd3,
    S_FINISH   = 3'd4
  } state_t;

  state_t      state_q;
  logic [31:0] acc_q, mcand_q, mplier_q;
  logic [31:0] rem_q, quot_q, divisor_q;
  logic [5:0]  cnt_q;

  logic [31:0] acc_d;
  logic [31:0] shift_d;
  logic [31:0] quot_shl_d;
  logic        last_step_d;

  always_comb begin
    acc_d       = mplier_q[0] ? alu_result : acc_q;
    shift_d     = {rem_q[30:0], quot_q[31]};
    quot_shl_d  = {quot_q[30:0], 1'b0};
    last_step_d = (cnt_q == 6'd31);
  end

  // ALU drive is purely a function of state and working registers.
  always_comb begin
    alu_op = 4'b0000;
    alu_a  = 32'd0;
    alu_b  = 32'd0;
    case (state_q)
      S_MUL_STEP: begin
        alu_op = C_ALU_ADD;
        alu_a  = acc_q;
        alu_b  = mcand_q;
      end
      S_DIV_CMP: begin
        alu_op = C_ALU_SLTU;
        alu_a  = shift_d;
        alu_b  = divisor_q;
      end
      S_DIV_SUB: begin
        alu_op = C_ALU_SUB;
        alu_a  = rem_q;
        alu_b  = divisor_q;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= S_IDLE;
      busy        <= 1'b0;
      done        <= 1'b0;
      result_lo   <= 32'd0;
      result_hi   <= 32'd0;
      div_by_zero <= 1'b0;
      acc_q       <= 32'd0;
      mcand_q     <= 32'd0;
      mplier_q    <= 32'd0;
      rem_q       <= 32'd0;
      quot_q      <= 32'd0;
      divisor_q   <= 32'd0;
      cnt_q       <= 6'd0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (start) begin
            busy <= 1'b1;
            if (!op) begin
              acc_q    <= 32'd0;
              mcand_q  <= a_in;
              mplier_q <= b_in;
              cnt_q    <= 6'd0;
              state_q  <= S_MUL_STEP;
            end else if (b_in != 32'd0) begin
              rem_q     <= 32'd0;
              quot_q    <= a_in;
              divisor_q <= b_in;
              cnt_q     <= 6'd0;
              state_q   <= S_DIV_CMP;
            end else begin
              result_lo   <= 32'hFFFF_FFFF;
              result_hi   <= a_in;
              div_by_zero <= 1'b1;
              done        <= 1'b1;
              state_q     <= S_FINISH;
            end
          end
        end

        S_MUL_STEP: begin
          acc_q    <= acc_d;
          mcand_q  <= {mcand_q[30:0], 1'b0};
          mplier_q <= {1'b0, mplier_q[31:1]};
          cnt_q    <= cnt_q + 6'd1;
          if (last_step_d) begin
            result_lo   <= acc_d;
            result_hi   <= 32'd0;
            div_by_zero <= 1'b0;
            done        <= 1'b1;
            state_q     <= S_FINISH;
          end
        end

        // rem[31] set means the shifted value overflowed 32 bits, so it
        // certainly exceeds the divisor even though SLTU cannot see it.
        S_DIV_CMP: begin
          rem_q  <= shift_d;
          quot_q <= quot_shl_d;
          if (rem_q[31] || alu_zero) begin
            state_q <= S_DIV_SUB;
          end else begin
            cnt_q <= cnt_q + 6'd1;
            if (last_step_d) begin
              result_lo   <= quot_shl_d;
              result_hi   <= shift_d;
              div_by_zero <= 1'b0;
              done        <= 1'b1;
              state_q     <= S_FINISH;
            end
          end
        end

        S_DIV_SUB: begin
          rem_q     <= alu_result;
          quot_q[0] <= 1'b1;
          cnt_q     <= cnt_q + 6'd1;
          if (last_step_d) begin
            result_lo   <= {quot_q[31:1], 1'b1};
            result_hi   <= alu_result;
            div_by_zero <= 1'b0;
            done        <= 1'b1;
            state_q     <= S_FINISH;
          end else begin
            state_q <= S_DIV_CMP;
          end
        end

        S_FINISH: begin
          done    <= 1'b0;
          busy    <= 1'b0;
          state_q <= S_IDLE;
        end

        default: begin
          done    <= 1'b0;
          busy    <= 1'b0;
          state_q <= S_IDLE;
        end
      endcase
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_alu_muldiv_seq.sv
// ============================================================================
// Module   : tb_alu_muldiv_seq
// Purpose  : Self-checking bench for alu_muldiv_seq with a behavioural ALU.
// Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_alu_muldiv_seq;

  logic        clk = 1'b0;
  logic        reset;
  logic        start;
  logic        op;
  logic [31:0] a_in;
  logic [31:0] b_in;
  logic        busy;
  logic        done;
  logic [31:0] result_lo;
  logic [31:0] result_hi;
  logic        div_by_zero;
  logic [3:0]  alu_op;
  logic [31:0] alu_a;
  logic [31:0] alu_b;
  logic [31:0] alu_result;
  logic        alu_zero;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  alu_muldiv_seq dut (
    .clk         (clk),
    .reset       (reset),
    .start       (start),
    .op          (op),
    .a_in        (a_in),
    .b_in        (b_in),
    .busy        (busy),
    .done        (done),
    .result_lo   (result_lo),
    .result_hi   (result_hi),
    .div_by_zero (div_by_zero),
    .alu_op      (alu_op),
    .alu_a       (alu_a),
    .alu_b       (alu_b),
    .alu_result  (alu_result),
    .alu_zero    (alu_zero)
  );

  // Datapath ALU the sequencer borrows.
  always_comb begin
    case (alu_op)
      4'b0000: alu_result = alu_a + alu_b;
      4'b0001: alu_result = alu_a - alu_b;
      4'b0101: alu_result = {31'd0, (alu_a < alu_b)};
      default: alu_result = 32'd0;
    endcase
    alu_zero = (alu_result == 32'd0);
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Issue one operation and check result, flags and completion cycle
  // against plain-arithmetic expectations. inj>0 pulses start in that cycle.
  task automatic do_op(input string tag, input logic o, input logic [31:0] a,
                       input logic [31:0] b, input int inj);
    logic [31:0] e_lo, e_hi;
    logic        e_dbz;
    int          e_lat, k;
    logic        busy_ok;
    if (!o) begin
      e_lo = a * b; e_hi = 32'd0; e_dbz = 1'b0; e_lat = 33;
    end else if (b == 32'd0) begin
      e_lo = 32'hFFFF_FFFF; e_hi = a; e_dbz = 1'b1; e_lat = 1;
    end else begin
      e_lo = a / b; e_hi = a % b; e_dbz = 1'b0; e_lat = 33 + $countones(a / b);
    end
    @(negedge clk);
    start = 1'b1; op = o; a_in = a; b_in = b;
    @(negedge clk);
    start = 1'b0;
    k = 1;
    busy_ok = 1'b1;
    while (done !== 1'b1 && k < 100) begin
      if (busy !== 1'b1) busy_ok = 1'b0;
      if (k == inj) begin
        start = 1'b1; op = ~o; a_in = $urandom; b_in = $urandom_range(3, 0);
      end else begin
        start = 1'b0;
      end
      @(negedge clk);
      k++;
    end
    start = 1'b0;
    check({tag, "_done_cycle"}, k, e_lat);
    check({tag, "_busy_run"}, {31'd0, busy_ok & busy}, 32'd1);
    check({tag, "_lo"}, result_lo, e_lo);
    check({tag, "_hi"}, result_hi, e_hi);
    check({tag, "_dbz"}, {31'd0, div_by_zero}, {31'd0, e_dbz});
    @(negedge clk);
    check({tag, "_idle_after"}, {30'd0, busy, done}, 32'd0);
    check({tag, "_hold_lo"}, result_lo, e_lo);
  endtask

  initial begin
    int  k;
    logic saw_done;
    reset = 1'b1; start = 1'b0; op = 1'b0; a_in = 32'd0; b_in = 32'd0;
    repeat (3) @(negedge clk);
    check("rst_busy_done", {30'd0, busy, done}, 32'd0);
    check("rst_lo", result_lo, 32'd0);
    check("rst_hi", result_hi, 32'd0);
    check("rst_dbz_aluop", {27'd0, div_by_zero, alu_op}, 32'd0);
    check("rst_alu_ab", alu_a | alu_b, 32'd0);
    reset = 1'b0;

    do_op("mul_7x6", 1'b0, 32'd7, 32'd6, 0);
    do_op("mul_ffxff", 1'b0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 0);
    do_op("mul_0x", 1'b0, 32'd0, 32'h1234_5678, 0);
    do_op("div_100_7", 1'b1, 32'd100, 32'd7, 0);
    do_op("div_ovr", 1'b1, 32'hFFFF_FFFF, 32'h8000_0001, 0);
    do_op("div_5_0", 1'b1, 32'd5, 32'd0, 0);
    do_op("mul_inj", 1'b0, 32'h0001_2345, 32'h0000_0ABC, 5);
    do_op("div_inj", 1'b1, 32'hDEAD_BEEF, 32'd13, 7);

    // Reset in cycle 10 of a divide discards it without a done pulse.
    @(negedge clk);
    start = 1'b1; op = 1'b1; a_in = 32'hFFFF_FFFF; b_in = 32'd3;
    @(negedge clk);
    start = 1'b0;
    for (k = 1; k < 10; k++) @(negedge clk);
    check("rst_mid_busy_c10", {31'd0, busy}, 32'd1);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    check("rst_mid_busy_done", {30'd0, busy, done}, 32'd0);
    check("rst_mid_results", result_lo | result_hi, 32'd0);
    check("rst_mid_dbz", {31'd0, div_by_zero}, 32'd0);
    check("rst_mid_alu", {28'd0, alu_op} | alu_a | alu_b, 32'd0);
    saw_done = 1'b0;
    for (int i = 0; i < 70; i++) begin
      @(negedge clk);
      if (done === 1'b1 || busy === 1'b1) saw_done = 1'b1;
    end
    check("rst_mid_no_done", {31'd0, saw_done}, 32'd0);
    do_op("mul_3x5", 1'b0, 32'd3, 32'd5, 0);

    for (int i = 0; i < 16; i++) begin
      logic        ro;
      logic [31:0] ra, rb;
      ro = $urandom_range(1, 0);
      ra = $urandom;
      case ($urandom_range(3, 0))
        0:       rb = 32'd0;
        1:       rb = $urandom_range(255, 1);
        2:       rb = $urandom >> $urandom_range(31, 0);
        default: rb = $urandom;
      endcase
      do_op("rand", ro, ra, rb, 0);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

`default_nettype wire
